// File: rtl/cpu_clock_pkg.sv
// Shared definitions for the CPU clock-enable block.
// Holds the control FSM state encoding, the cycle_count width, and a
// helper function that sizes small counters so they are never zero bits wide.
package cpu_clock_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STEP   = 2'd1,
    HALTED = 2'd2
  } cpu_state_e;

  localparam int COUNT_W = 16;

  // Bits needed to hold values 0..max_value, never less than one bit.
  function automatic int counter_width(input int max_value);
    int w;
    w = 1;
    while ((1 << w) <= max_value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Step-button conditioning for the CPU clock-enable block.
// Brings the raw button into the clk domain through two flops, then accepts a
// new level only after it has been stable for debounce_cycles_to_wait cycles.
// A one-cycle step_req pulse marks each accepted 0->1 change.
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   raw       bouncing, asynchronous button level (high = pressed)
//   step_req  one-cycle pulse per debounced press
module button_debouncer
  import cpu_clock_pkg::*;
#(
  parameter int debounce_cycles_to_wait = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic step_req
);

  localparam int CNT_W = counter_width(debounce_cycles_to_wait);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(debounce_cycles_to_wait - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             accepted_r;
  logic [CNT_W-1:0] cnt_r;
  logic             pulse_r;

  // Two-flop synchronizer; nothing else looks at raw directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // Stability counter, accepted level and press pulse. The counter resets
  // whenever the synchronized level agrees with the accepted one, so any
  // bounce restarts the qualification window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accepted_r <= 1'b0;
      cnt_r      <= '0;
      pulse_r    <= 1'b0;
    end else begin
      if (sync2_r == accepted_r) begin
        cnt_r      <= '0;
        accepted_r <= accepted_r;
        pulse_r    <= 1'b0;
      end else if (cnt_r == CNT_LAST) begin
        // This cycle completes the stable run: take the new level.
        cnt_r      <= '0;
        accepted_r <= sync2_r;
        pulse_r    <= sync2_r;
      end else begin
        cnt_r      <= cnt_r + CNT_W'(1);
        accepted_r <= accepted_r;
        pulse_r    <= 1'b0;
      end
    end
  end

  assign step_req = pulse_r;

endmodule

// File: rtl/cpu_clock_enable.sv
// CPU clock-enable generator.
// In RUN it strobes cpu_ce once every DIV = source_clk/target_clk cycles; in
// STEP it strobes once per debounced press of manual_clk; a halt request seen
// during a strobe parks the block in HALTED until reset. cycle_count counts
// every strobe issued and wraps at 16 bits.
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   manual_clk   raw step button (high = pressed)
//   select       0 = auto run, 1 = manual step
//   halt         halt request, sampled only while cpu_ce is high
//   cpu_ce       one-cycle clock-enable strobe
//   halted       high while in HALTED
//   cycle_count  strobes issued since reset
module cpu_clock_enable
  import cpu_clock_pkg::*;
#(
  parameter int source_clk              = 100,
  parameter int target_clk              = 50,
  parameter int debounce_cycles_to_wait = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               manual_clk,
  input  logic               select,
  input  logic               halt,
  output logic               cpu_ce,
  output logic               halted,
  output logic [COUNT_W-1:0] cycle_count
);

  localparam int DIV   = source_clk / target_clk;
  localparam int DIV_W = counter_width(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  cpu_state_e         state_r;
  cpu_state_e         state_next_s;
  logic [DIV_W-1:0]   div_r;
  logic [DIV_W-1:0]   div_next_s;
  logic               cpu_ce_r;
  logic               ce_next_s;
  logic               halted_r;
  logic [COUNT_W-1:0] cycle_count_r;
  logic               step_req_s;

  button_debouncer #(
    .debounce_cycles_to_wait(debounce_cycles_to_wait)
  ) u_button (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw     (manual_clk),
    .step_req(step_req_s)
  );

  // Next-state logic. cpu_ce is registered, so ce_next_s is the strobe for the
  // coming cycle; a RUN strobe is due when the divider lands on DIV-1.
  always_comb begin
    state_next_s = state_r;
    div_next_s   = div_r;
    ce_next_s    = 1'b0;
    if (cpu_ce_r && halt) begin
      state_next_s = HALTED;
      div_next_s   = '0;
    end else begin
      case (state_r)
        RUN: begin
          if (select) begin
            state_next_s = STEP;
            div_next_s   = '0;
          end else begin
            if (div_r == DIV_LAST) begin
              div_next_s = '0;
            end else begin
              div_next_s = div_r + DIV_W'(1);
            end
            ce_next_s = (div_next_s == DIV_LAST);
          end
        end
        STEP: begin
          if (!select) begin
            state_next_s = RUN;
            div_next_s   = '0;
          end else begin
            ce_next_s = step_req_s;
          end
        end
        HALTED: begin
          state_next_s = HALTED;
          div_next_s   = '0;
        end
        default: begin
          state_next_s = RUN;
          div_next_s   = '0;
        end
      endcase
    end
  end

  // Control FSM with registered strobe, halted flag and strobe counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= RUN;
      div_r         <= '0;
      cpu_ce_r      <= 1'b0;
      halted_r      <= 1'b0;
      cycle_count_r <= '0;
    end else begin
      state_r  <= state_next_s;
      div_r    <= div_next_s;
      cpu_ce_r <= ce_next_s;
      halted_r <= (state_next_s == HALTED);
      if (ce_next_s) begin
        cycle_count_r <= cycle_count_r + COUNT_W'(1);
      end else begin
        cycle_count_r <= cycle_count_r;
      end
    end
  end

  assign cpu_ce      = cpu_ce_r;
  assign halted      = halted_r;
  assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_cpu_clock_enable.sv
module tb_cpu_clock_enable;

  localparam int DIV = 2;
  localparam int NDB = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, manual_clk, select, halt;
  logic        cpu_ce, halted;
  logic [15:0] cycle_count;

  logic        rst_n_w, tie_lo;
  logic        cpu_ce_w, halted_w;
  logic [15:0] cycle_count_w;

  int checks = 0;
  int passes = 0;

  cpu_clock_enable dut (
    .clk(clk), .rst_n(rst_n), .manual_clk(manual_clk), .select(select), .halt(halt),
    .cpu_ce(cpu_ce), .halted(halted), .cycle_count(cycle_count)
  );

  // second instance with DIV = 1 so the 16-bit wrap is reachable quickly
  cpu_clock_enable #(.source_clk(100), .target_clk(100), .debounce_cycles_to_wait(10)) dut_wrap (
    .clk(clk), .rst_n(rst_n_w), .manual_clk(tie_lo), .select(tie_lo), .halt(tie_lo),
    .cpu_ce(cpu_ce_w), .halted(halted_w), .cycle_count(cycle_count_w)
  );

  // ---------------- behavioural reference model ----------------
  int          m_k, m_e, m_mode, m_run;   // mode: 0 run, 1 step, 2 halted
  bit          m_ce, m_halted, m_acc, m_pulse, m_d1, m_d2;
  logic [15:0] m_count;

  task automatic model_reset();
    m_k = 0; m_e = 0; m_mode = 0; m_run = 0;
    m_ce = 1'b0; m_halted = 1'b0; m_acc = 1'b0; m_pulse = 1'b0;
    m_d1 = 1'b0; m_d2 = 1'b0; m_count = 16'h0000;
  endtask

  task automatic model_edge();
    bit req, ce_was, s;
    m_k++;
    req = m_pulse;
    ce_was = m_ce;
    s = m_d2;            // button level as seen two clocks later
    m_d2 = m_d1;
    m_d1 = manual_clk;
    m_pulse = 1'b0;
    if (s != m_acc) begin
      m_run++;
      if (m_run == NDB) begin
        m_acc = s; m_run = 0; m_pulse = s;
      end
    end else begin
      m_run = 0;
    end
    m_ce = 1'b0;
    if (m_mode != 2 && ce_was && halt) m_mode = 2;
    else if (m_mode == 0) begin
      if (select) m_mode = 1;
      else m_ce = (((m_k - m_e) % DIV) == DIV - 1);
    end else if (m_mode == 1) begin
      if (!select) begin m_mode = 0; m_e = m_k; end
      else m_ce = req;
    end
    m_halted = (m_mode == 2);
    if (m_ce) m_count = m_count + 16'h0001;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; manual_clk = 1'b0; select = 1'b0; halt = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cpu_ce, halted, cycle_count} !== 18'd0)
      $display("FAIL reset_state got ce=%b halted=%b count=%h want 0/0/0000", cpu_ce, halted, cycle_count);
    else passes++;
    rst_n = 1'b1;
  endtask

  task automatic test_auto_run();
    do_reset();
    select = 1'b0; halt = 1'b0; manual_clk = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if ({cpu_ce, halted, cycle_count} !== {m_ce, m_halted, m_count})
        $display("FAIL auto_run_model cyc=%0d got %b/%b/%h want %b/%b/%h", i, cpu_ce, halted, cycle_count, m_ce, m_halted, m_count);
      else passes++;
      checks++;
      if (cpu_ce !== ((i % 2) == 1))
        $display("FAIL auto_run_pattern cyc=%0d got ce=%b want %b", i, cpu_ce, (i % 2) == 1);
      else passes++;
    end
    checks++;
    if (cycle_count !== 16'd5) $display("FAIL auto_run_count got %0d want 5", cycle_count);
    else passes++;
  endtask

  task automatic test_manual_hold();
    int strobes, strobe_at;
    do_reset();
    select = 1'b1; halt = 1'b0; manual_clk = 1'b0;
    repeat (5) step();
    strobes = 0; strobe_at = -1;
    for (int i = 1; i <= 40; i++) begin
      manual_clk = (i <= 20);
      step();
      checks++;
      if ({cpu_ce, halted, cycle_count} !== {m_ce, m_halted, m_count})
        $display("FAIL manual_hold_model cyc=%0d got %b/%b/%h want %b/%b/%h", i, cpu_ce, halted, cycle_count, m_ce, m_halted, m_count);
      else passes++;
      if (cpu_ce === 1'b1) begin strobes++; strobe_at = i; end
    end
    manual_clk = 1'b0;
    checks++;
    if (strobes != 1 || strobe_at != 13)
      $display("FAIL manual_hold_strobe got count=%0d at=%0d want 1 at 13", strobes, strobe_at);
    else passes++;
  endtask

  task automatic test_bounce();
    int lvl[15] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int len[15] = '{1, 1, 2, 2, 2, 2, 4, 4, 11, 20, 20, 1, 2, 2, 1};
    int grp[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3};
    int want[4] = '{0, 1, 1, 0};
    int got[4];
    int cyc;
    got = '{0, 0, 0, 0};
    cyc = 0;
    select = 1'b1; halt = 1'b0;
    for (int s = 0; s < 16; s++) begin
      int n, g;
      n = (s < 15) ? len[s] : 30;          // trailing quiet low of the bounced release
      g = (s < 15) ? grp[s] : 3;
      manual_clk = (s < 15) ? (lvl[s] == 1) : 1'b0;
      for (int i = 0; i < n; i++) begin
        step();
        cyc++;
        checks++;
        if ({cpu_ce, halted, cycle_count} !== {m_ce, m_halted, m_count})
          $display("FAIL bounce_model cyc=%0d got %b/%b/%h want %b/%b/%h", cyc, cpu_ce, halted, cycle_count, m_ce, m_halted, m_count);
        else passes++;
        if (cpu_ce === 1'b1) got[g]++;
      end
    end
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (got[g] != want[g]) $display("FAIL bounce_group%0d strobes got %0d want %0d", g, got[g], want[g]);
      else passes++;
    end
  endtask

  task automatic test_halt();
    int halted_at, strobes;
    do_reset();
    select = 1'b0; halt = 1'b1; manual_clk = 1'b0;
    halted_at = -1; strobes = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if ({cpu_ce, halted, cycle_count} !== {m_ce, m_halted, m_count})
        $display("FAIL halt_model cyc=%0d got %b/%b/%h want %b/%b/%h", i, cpu_ce, halted, cycle_count, m_ce, m_halted, m_count);
      else passes++;
      if (cpu_ce === 1'b1) strobes++;
      if (halted === 1'b1 && halted_at < 0) halted_at = i;
    end
    checks++;
    if (halted_at != 2 || strobes != 1)
      $display("FAIL halt_entry got halted_at=%0d strobes=%0d want 2 and 1", halted_at, strobes);
    else passes++;
    halt = 1'b0; strobes = 0;
    for (int i = 0; i < 120; i++) begin
      select = ((i / 30) % 2) == 1;
      manual_clk = ((i % 30) >= 5) && ((i % 30) < 22);
      step();
      if (cpu_ce === 1'b1 || halted !== 1'b1) strobes++;
    end
    manual_clk = 1'b0;
    checks++;
    if (strobes != 0 || cycle_count !== 16'd1)
      $display("FAIL halt_sticky got bad_cycles=%0d count=%0d want 0 and 1", strobes, cycle_count);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int guard;
    do_reset();
    select = 1'b1; halt = 1'b0; manual_clk = 1'b0;
    repeat (4) step();
    manual_clk = 1'b1;
    repeat (6) step();           // debounce counter is mid-way here
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cpu_ce, halted, cycle_count} !== 18'd0)
      $display("FAIL reset_mid_debounce got %b/%b/%h want 0/0/0000", cpu_ce, halted, cycle_count);
    else passes++;
    model_reset();
    manual_clk = 1'b0;
    select = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    guard = 0;
    do begin step(); guard++; end while (cpu_ce !== 1'b1 && guard < 10);
    checks++;
    if (cpu_ce !== 1'b1) $display("FAIL reset_mid_wait_strobe got ce=%b want 1 within 10 clk", cpu_ce);
    else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cpu_ce, halted, cycle_count} !== 18'd0)
      $display("FAIL reset_mid_strobe got %b/%b/%h want 0/0/0000", cpu_ce, halted, cycle_count);
    else passes++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (cpu_ce !== ((i % 2) == 1) || cycle_count !== 16'((i + 1) / 2))
        $display("FAIL reset_mid_rerun cyc=%0d got ce=%b count=%0d want %b %0d", i, cpu_ce, cycle_count, (i % 2) == 1, (i + 1) / 2);
      else passes++;
    end
  endtask

  task automatic test_random();
    int rem;
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      select = 1'b0; halt = 1'b0; manual_clk = 1'b0; rem = 0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 39) == 0) select = ~select;
        if (rem == 0) begin
          manual_clk = $urandom_range(0, 1);
          rem = $urandom_range(1, 25);
        end
        rem--;
        halt = ($urandom_range(0, 149) == 0);
        step();
        checks++;
        if ({cpu_ce, halted, cycle_count} !== {m_ce, m_halted, m_count})
          $display("FAIL random_model seg=%0d cyc=%0d got %b/%b/%h want %b/%b/%h", seg, i, cpu_ce, halted, cycle_count, m_ce, m_halted, m_count);
        else passes++;
      end
      halt = 1'b0;
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp;
    @(negedge clk);
    rst_n_w = 1'b1;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    exp = 16'hFFFE;
    checks++;
    if (cycle_count_w !== exp) $display("FAIL wrap_preload got %h want %h", cycle_count_w, exp);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp = exp + 16'h0001;
      checks++;
      if (cpu_ce_w !== 1'b1 || cycle_count_w !== exp)
        $display("FAIL wrap_step%0d got ce=%b count=%h want 1 %h", i, cpu_ce_w, cycle_count_w, exp);
      else passes++;
    end
  endtask

  initial begin
    rst_n_w = 1'b0; tie_lo = 1'b0;
    test_reset();
    test_auto_run();
    test_manual_hold();
    test_bounce();
    test_halt();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cpu_clock_enable.md
CPU_CLOCK_ENABLE -- requirements
Module: cpu_clock_enable

Interface
REQ-001 Parameter source_clk, default 100, frequency of clk in Hz.
REQ-002 Parameter target_clk, default 50, frequency of auto-run enable strobes in Hz; DIV = source_clk/target_clk, integer, >= 1.
REQ-003 Parameter debounce_cycles_to_wait, default 10, consecutive stable clk cycles needed to accept a new manual_clk level.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 manual_clk  input  1  raw, bouncing, asynchronous step button; high = pressed.
REQ-007 select  input  1  0 = auto run from divider, 1 = manual step.
REQ-008 halt  input  1  CPU halt request, synchronous to clk.
REQ-009 cpu_ce  output  1  one-cycle clock-enable strobe that advances the CPU.
REQ-010 halted  output  1  high while in HALTED.
REQ-011 cycle_count  output  16  number of cpu_ce strobes issued since reset.

Function
REQ-012 manual_clk SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Debounce: counter clears whenever the synchronized level equals the accepted level; otherwise it increments; when it reaches debounce_cycles_to_wait, the accepted level takes the synchronized level and the counter clears.
REQ-014 A step request SHALL be a one-cycle pulse on a 0->1 change of the accepted level; a glitch shorter than debounce_cycles_to_wait cycles SHALL produce no request.
REQ-015 FSM states RUN, STEP, HALTED; the transition is evaluated each clk.
REQ-016 RUN: divider counts 0..DIV-1 and wraps; cpu_ce = 1 for exactly the cycle in which the count equals DIV-1; with DIV = 1, cpu_ce is high every cycle.
REQ-017 RUN -> STEP when select = 1; the divider clears to 0.
REQ-018 STEP -> RUN when select = 0; the divider restarts at 0, so the first strobe follows DIV cycles later.
REQ-019 STEP: cpu_ce = 1 for exactly one cycle, on the cycle after the step request pulse.
REQ-020 Step requests SHALL be ignored in RUN and HALTED; requests are not queued.
REQ-021 If halt = 1 in a cycle where cpu_ce = 1, the state SHALL become HALTED on the next cycle; halt is ignored when cpu_ce = 0.
REQ-022 HALTED: cpu_ce = 0 and halted = 1; HALTED exits only on reset; select and manual_clk have no effect.
REQ-023 cycle_count SHALL increment by 1 on each cpu_ce and wrap from 0xFFFF to 0x0000.
REQ-024 A select change in the same cycle as a strobe: the strobe is issued and the state change applies on the next cycle.

Reset
REQ-025 On rst_n = 0: state RUN, divider 0, synchronizer flops 0, accepted level 0, debounce counter 0, cpu_ce 0, halted 0, cycle_count 0.
REQ-026 Reset SHALL take effect immediately and asynchronously, including while a strobe is high; operation resumes on the first clk edge after rst_n rises.

Structure
REQ-027 FSM state encodings (RUN = 2'd0, STEP = 2'd1, HALTED = 2'd2) and the cycle_count width SHALL be defined in the shared package cpu_clock_pkg.
REQ-028 The synchronizer, debouncer, and rising-edge pulse SHALL form one sub-module, button_debouncer, parameterized by debounce_cycles_to_wait.

Verification
REQ-029 Reset deassert with select = 0, default parameters -> cpu_ce high every 2nd clk; cycle_count = 5 after 10 clk.
REQ-030 select = 1, manual_clk held high for 20 clk -> exactly one cpu_ce, at 2 + 10 + 1 clk after the rising edge; no strobe on release.
REQ-031 select = 1, manual_clk high/low pulses of 1, 2, 2, 4 clk, then high for 11 clk -> exactly one cpu_ce; a bounced release produces 0 strobes.
REQ-032 In RUN with halt = 1 -> halted = 1 one cycle after the next cpu_ce; no further strobes, including after button presses and select toggles.
REQ-033 Preload near wrap (0xFFFE) and run 3 strobes -> cycle_count reads 0xFFFF, 0x0000, 0x0001.
REQ-034 Pull rst_n low mid-debounce and mid-strobe -> all outputs 0 immediately; after release, behaviour is identical to REQ-029.
